// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller.
// A single one-bit full adder/subtractor slice is stepped over a WIDTH-bit
// operand pair, LSB first, with a carry flip-flop linking successive bits.
// Subtraction is a + ~b + 1: b is inverted bit by bit and the carry starts at 1.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] last_bit = CW'(WIDTH - 1);
  localparam logic [CW-1:0] pre_msb  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             op_l;
  logic             c;
  logic             c_msb_in;
  logic [CW-1:0]    cnt;

  logic             bb;
  logic             s;
  logic             c_next;

  // One-bit slice on the current LSB of the operand shift registers
  always_comb begin
    bb     = b_sh[0] ^ op_l;
    s      = a_sh[0] ^ bb ^ c;
    c_next = (a_sh[0] & bb) | (bb & c) | (a_sh[0] & c);
  end

  // Sequencer: latch operands on start, step one bit per clock, pulse done
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      op_l     <= 1'b0;
      c        <= 1'b0;
      c_msb_in <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            op_l  <= op;
            c     <= op;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          result <= {s, result[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          c      <= c_next;
          cnt    <= cnt + CW'(1);
          if (cnt == pre_msb) begin
            c_msb_in <= c_next;
          end
          if (cnt == last_bit) begin
            cout     <= c_next;
            overflow <= c_next ^ c_msb_in;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Testbench for serial_addsub_ctrl (WIDTH=8).
// Stimulus pushes the expected result into a queue; a monitor pops and
// compares whenever the DUT pulses done.
module tb_serial_addsub_ctrl;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .result(result),
    .cout(cout),
    .overflow(overflow)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point feeding the pass/fail counters
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Independent arithmetic model: (a +/- b) mod 2^WIDTH with carry and overflow
  function automatic exp_t refModel(input logic sub, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t e;
    logic [WIDTH:0] wide;
    if (!sub) begin
      wide  = {1'b0, x} + {1'b0, y};
      e.res = wide[WIDTH-1:0];
      e.c   = wide[WIDTH];
      e.v   = (x[WIDTH-1] == y[WIDTH-1]) && (e.res[WIDTH-1] != x[WIDTH-1]);
    end else begin
      e.res = x - y;
      e.c   = (x >= y);
      e.v   = (x[WIDTH-1] != y[WIDTH-1]) && (e.res[WIDTH-1] != x[WIDTH-1]);
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (done) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_done", done, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("cout", cout, e.c);
        checkOutput("overflow", overflow, e.v);
      end
    end
  end

  // Issue one operation, queue its expectation and check latency/busy length
  task automatic applyStimulus(input logic sub, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input exp_t e);
    int k;
    int busyCycles;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    op    = sub;
    a     = x;
    b     = y;
    expq.push_back(e);
    k = 0;
    busyCycles = 0;
    seen = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      start = 1'b0;
      a     = $urandom_range(255);
      b     = $urandom_range(255);
      op    = $urandom_range(1);
      k++;
      if (busy) busyCycles++;
      if (done) seen = 1;
    end
    checkOutput("done_latency", k, WIDTH + 1);
    checkOutput("busy_cycles", busyCycles, WIDTH);
  endtask

  // Wait a number of cycles requiring the block to stay idle
  task automatic idleCheck(input string name, input int cycles);
    int busySeen;
    busySeen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy || done) busySeen++;
    end
    checkOutput(name, busySeen, 0);
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_result"}, result, 0);
    checkOutput({tag, "_cout"}, cout, 0);
    checkOutput({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    checkCleared("reset");
    reset = 1'b0;

    // Directed vectors with hand-computed results
    applyStimulus(1'b0, 8'h35, 8'h4A, '{res: 8'h7F, c: 1'b0, v: 1'b0});
    applyStimulus(1'b0, 8'hFF, 8'h01, '{res: 8'h00, c: 1'b1, v: 1'b0});
    applyStimulus(1'b0, 8'h7F, 8'h01, '{res: 8'h80, c: 1'b0, v: 1'b1});
    applyStimulus(1'b1, 8'h10, 8'h20, '{res: 8'hF0, c: 1'b0, v: 1'b0});
    applyStimulus(1'b1, 8'h80, 8'h01, '{res: 8'h7F, c: 1'b1, v: 1'b1});

    // Start pulse and operand changes during RUN are ignored
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'h05; b = 8'h03;
    expq.push_back('{res: 8'h08, c: 1'b0, v: 1'b0});
    repeat (3) @(negedge clk);
    start = 1'b1; op = 1'b1; a = 8'hAA; b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("ignored_start_queue", expq.size(), 0);
    // Next start right after the done cycle is accepted
    applyStimulus(1'b0, 8'h22, 8'h11, '{res: 8'h33, c: 1'b0, v: 1'b0});

    // Reset during the 4th RUN cycle aborts without a done pulse
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'h12; b = 8'h34;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkCleared("abort");
    reset = 1'b0;
    idleCheck("abort_no_done", 12);
    applyStimulus(1'b0, 8'h01, 8'h01, '{res: 8'h02, c: 1'b0, v: 1'b0});

    // Reset and start together: reset wins
    @(negedge clk);
    reset = 1'b1; start = 1'b1; op = 1'b0; a = 8'h44; b = 8'h44;
    @(negedge clk);
    checkCleared("reset_start");
    reset = 1'b0; start = 1'b0;
    idleCheck("reset_start_idle", 12);

    // Random sweep against the arithmetic model
    for (int i = 0; i < 500; i++) begin
      logic             rs;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      rs = 1'($urandom_range(1));
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      applyStimulus(rs, ra, rb, refModel(rs, ra, rb));
    end

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
Bit-serial add/subtract controller. It sequences a single one-bit full adder/subtractor slice over a WIDTH-bit operand pair, LSB first, one bit per clock. A registered carry flip-flop links the bits. The block accepts a start request, runs WIDTH bit cycles, then presents the result with carry-out and signed overflow. It sits between the operand source (switch/register front end) and the result display/consumer in the lab datapath.

Parameters:
WIDTH, 8, operand and result width in bits (must be >= 2)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to begin an operation; sampled only in IDLE
op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while bits are being processed (RUN state)
done  output  1  one-cycle pulse: result/cout/overflow valid
result  output  WIDTH  sum/difference; held until next accepted start
cout  output  1  final carry out (subtract: 1 = no borrow, a >= b unsigned)
overflow  output  1  signed two's-complement overflow of the operation

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high; it is sampled only on the clk rising edge.
- Reset state: IDLE. busy=0, done=0, result=0, cout=0, overflow=0. Internal bit counter, carry flop and operand shift registers are cleared.
- Bit slice function, evaluated each RUN cycle on bit i:
  - bb = b[i] ^ op_l
  - s = a[i] ^ bb ^ c
  - c_next = (a[i]&bb) | (bb&c) | (a[i]&c)
- States:
  - IDLE: busy=0, done=0.
    - On start=1, latch a, b and op into op_l.
    - Set carry c = op_l, so subtract computes a + ~b + 1.
    - Set counter = 0 and go to RUN.
    - The result, cout and overflow registers from the previous operation stay unchanged until the first RUN edge.
  - RUN: busy=1.
    - Each edge: compute bit counter with the slice function.
    - Shift s into result from the MSB side, so that after WIDTH shifts bit 0 sits at the LSB.
    - c <= c_next; counter increments.
    - When counter == WIDTH-2, the carry being computed is into the MSB. Capture it as c_msb_in.
    - On the edge where counter == WIDTH-1 (MSB processed): cout <= c_next, overflow <= c_next ^ c_msb_in, go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency: start is sampled high at edge E0. busy is high from after E0 through edge E0+WIDTH. done is high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 edges after the start edge.
- Back-to-back: the earliest next start is accepted in the IDLE cycle after DONE. Throughput is one operation per WIDTH+2 cycles.
- start in RUN or DONE is ignored and not queued.
- Changes on a, b or op after the start edge have no effect on the running operation.
- Reset asserted mid-operation: the next edge aborts to IDLE with all outputs cleared as at reset. No done pulse is issued for the aborted operation.
- reset and start high on the same edge: reset wins.
- Width rule: all arithmetic is modulo 2^WIDTH; the carry out of the MSB is reported only via cout.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, add 0x35+0x4A -> done at start edge+9, result=0x7F, cout=0, overflow=0; busy high for exactly 8 cycles.
- Add 0xFF+0x01 -> result=0x00, cout=1, overflow=0. Then add 0x7F+0x01 -> result=0x80, cout=0, overflow=1.
- Subtract 0x10-0x20 -> result=0xF0, cout=0 (borrow), overflow=0. Subtract 0x80-0x01 -> result=0x7F, cout=1, overflow=1.
- Start and operand changes while busy:
  - Start 0x05+0x03, then pulse start with a=0xAA, b=0x55, op=1 during RUN.
  - Required: result=0x08, single done pulse, second request ignored.
  - A new start in the IDLE cycle after done is accepted.
- Reset mid-operation: reset asserted at the 4th RUN cycle -> next cycle busy=0, done=0, result=0, cout=0, overflow=0. No done pulse follows. A subsequent 0x01+0x01 returns 0x02.
- reset=1 and start=1 on the same edge -> block stays in IDLE with outputs zero. Also sweep random a, b, op (>=500 vectors) against a reference (a ± b) mod 256, including unsigned carry/borrow and signed overflow.
